lfsr_clk_gen: RTL and testbench

LFSR_CLK_GEN -- requirements
Module: lfsr_clk_gen

---
 rtl/lfsr_clk_pkg.sv | 25 ++
 rtl/lfsr_clk_gen_lfsr8_step.sv | 36 +++
 rtl/lfsr_clk_gen.sv | 116 +++++++++++
 tb/tb_lfsr_clk_gen.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/lfsr_clk_pkg.sv
// Shared constants for the LFSR clock generator: register map, CTRL bits,
// LFSR tap mask and the lockup-avoidance seed substitute.
package lfsr_clk_pkg;

   localparam logic [1:0] ADDR_CTRL    = 2'd0;
   localparam logic [1:0] ADDR_DIVISOR = 2'd1;
   localparam logic [1:0] ADDR_SEED    = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_LOAD_BIT = 1;

   // Feedback taps at bits 7,5,4,3: x^8+x^6+x^5+x^4+1
   localparam logic [7:0] LFSR_TAPS     = 8'hB8;
   localparam logic [7:0] LFSR_ZERO_SUB = 8'h01;

   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & LFSR_TAPS)};
   endfunction

   function automatic logic [7:0] seed_safe(input logic [7:0] s);
      return (s == 8'h00) ? LFSR_ZERO_SUB : s;
   endfunction

endpackage

// File: rtl/lfsr_clk_gen_lfsr8_step.sv
// 8-bit Fibonacci LFSR register with seed load (priority over step) and
// all-zero seed substitution.
module lfsr8_step
   import lfsr_clk_pkg::*;
#(
   parameter logic [7:0] RESET_SEED = 8'h01
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_step,
   input  logic       i_load,
   input  logic [7:0] i_seed,
   output logic [7:0] o_lfsr
);

   logic [7:0] r_lfsr;
   logic [7:0] w_next;

   always_comb begin
      w_next = r_lfsr;
      if (i_load)
         w_next = seed_safe(i_seed);
      else if (i_step)
         w_next = lfsr_next(r_lfsr);
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_lfsr <= seed_safe(RESET_SEED);
      else
         r_lfsr <= w_next;
   end

   assign o_lfsr = r_lfsr;

endmodule

// File: rtl/lfsr_clk_gen.sv
// Avalon-MM programmable clock divider whose rising edges advance an 8-bit
// LFSR; exposes the divided level and LFSR state to a downstream PIO.
module lfsr_clk_gen
   import lfsr_clk_pkg::*;
#(
   parameter int         DIV_W      = 24,
   parameter logic [7:0] RESET_SEED = 8'h01
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        lfsr_clk,
   output logic [7:0]  lfsr_data,
   output logic [7:0]  out_port
);

   logic             r_enable;
   logic [DIV_W-1:0] r_divisor;
   logic [7:0]       r_seed;
   logic [DIV_W-1:0] r_cnt;
   logic             r_lfsr_clk;
   logic [31:0]      r_readdata;

   logic        w_wr;
   logic        w_wr_ctrl;
   logic        w_wr_div;
   logic        w_wr_seed;
   logic        w_load;
   logic        w_toggle;
   logic        w_step;
   logic [7:0]  w_lfsr;
   logic [31:0] w_rd_mux;
   logic        w_unused_wdata;

   assign w_wr      = chipselect && !write_n;
   assign w_wr_ctrl = w_wr && (address == ADDR_CTRL);
   assign w_wr_div  = w_wr && (address == ADDR_DIVISOR);
   assign w_wr_seed = w_wr && (address == ADDR_SEED);
   assign w_load    = w_wr_ctrl && writedata[CTRL_LOAD_BIT];

   // A divisor write restarts the half period, so it suppresses any toggle
   assign w_toggle = r_enable && !w_wr_div && (r_cnt == r_divisor);
   assign w_step   = w_toggle && !r_lfsr_clk;

   assign w_unused_wdata = ^writedata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_enable  <= 1'b0;
         r_divisor <= '0;
         r_seed    <= RESET_SEED;
      end else begin
         if (w_wr_ctrl) r_enable  <= writedata[CTRL_EN_BIT];
         if (w_wr_div)  r_divisor <= writedata[DIV_W-1:0];
         if (w_wr_seed) r_seed    <= writedata[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt      <= '0;
         r_lfsr_clk <= 1'b0;
      end else if (w_wr_div) begin
         r_cnt <= '0;
      end else if (w_toggle) begin
         r_cnt      <= '0;
         r_lfsr_clk <= ~r_lfsr_clk;
      end else if (r_enable) begin
         r_cnt <= r_cnt + DIV_W'(1);
      end
   end

   // Load samples the stored seed, so a same-cycle SEED write only affects later loads
   lfsr8_step #(
      .RESET_SEED (RESET_SEED)
   ) u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .i_step (w_step),
      .i_load (w_load),
      .i_seed (r_seed),
      .o_lfsr (w_lfsr)
   );

   always_comb begin
      w_rd_mux = '0;
      case (address)
         ADDR_CTRL:    w_rd_mux[CTRL_EN_BIT] = r_enable;
         ADDR_DIVISOR: w_rd_mux[DIV_W-1:0]   = r_divisor;
         ADDR_SEED:    w_rd_mux[7:0]         = r_seed;
         ADDR_STATUS: begin
            w_rd_mux[15:8] = w_lfsr;
            w_rd_mux[1]    = r_enable;
            w_rd_mux[0]    = r_lfsr_clk;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_readdata <= '0;
      else
         r_readdata <= w_rd_mux;
   end

   assign readdata  = r_readdata;
   assign lfsr_clk  = r_lfsr_clk;
   assign lfsr_data = w_lfsr;
   assign out_port  = {6'b0, w_lfsr[0], r_lfsr_clk};

endmodule

// File: tb/tb_lfsr_clk_gen.sv
// Directed bench for lfsr_clk_gen: register table plus hand-written
// divider, sequence, reset, collision and reconfiguration sequences.
module tb_lfsr_clk_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        lfsr_clk;
   logic [7:0]  lfsr_data;
   logic [7:0]  out_port;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [1:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[10];
   logic [7:0] seq_exp[6];

   lfsr_clk_gen #(
      .DIV_W      (24),
      .RESET_SEED (8'h01)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .lfsr_clk   (lfsr_clk),
      .lfsr_data  (lfsr_data),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Called at a negedge; the write lands on the following posedge
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int early;

      vecs[0] = '{2'd1, 32'hFFFF_FFFF, 32'h00FF_FFFF};
      vecs[1] = '{2'd1, 32'h0000_0004, 32'h0000_0004};
      vecs[2] = '{2'd2, 32'h1234_56A5, 32'h0000_00A5};
      vecs[3] = '{2'd0, 32'hFFFF_FFFC, 32'h0000_0000};
      vecs[4] = '{2'd3, 32'hFFFF_FFFF, 32'h0000_0100};
      vecs[5] = '{2'd0, 32'h0000_0002, 32'h0000_0000};
      vecs[6] = '{2'd3, 32'h0000_0000, 32'h0000_A500};
      vecs[7] = '{2'd2, 32'h0000_0000, 32'h0000_0000};
      vecs[8] = '{2'd0, 32'h0000_0002, 32'h0000_0000};
      vecs[9] = '{2'd3, 32'h0000_0000, 32'h0000_0100};
      seq_exp = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47};

      reset      = 1'b1;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      tick(3);
      reset = 1'b0;
      chk("init_lfsr_clk", 32'(lfsr_clk), 32'h0);
      chk("init_lfsr_data", 32'(lfsr_data), 32'h01);
      chk("init_readdata", readdata, 32'h0);
      chk("init_out_port", 32'(out_port), 32'h02);

      // Register map: write then read back
      for (int i = 0; i < 10; i++) begin
         wr(vecs[i].addr, vecs[i].wdata);
         @(negedge clk);
         chk($sformatf("reg_vec%0d", i), readdata, vecs[i].exp_rd);
      end
      chk("zero_seed_lfsr", 32'(lfsr_data), 32'h01);

      // Divider: DIVISOR=4, half period 5
      wr(2'd1, 32'd4);
      wr(2'd0, 32'd1);
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         chk($sformatf("div_clk_k%0d", k), 32'(lfsr_clk), 32'((k / 5) % 2));
         if (k == 5)  chk("div_lfsr_rise1", 32'(lfsr_data), 32'h02);
         if (k == 15) chk("div_lfsr_rise2", 32'(lfsr_data), 32'h04);
      end

      // Disable holds everything
      wr(2'd0, 32'd0);
      tick(10);
      chk("hold_clk", 32'(lfsr_clk), 32'h0);
      chk("hold_lfsr", 32'(lfsr_data), 32'h04);
      address = 2'd3;
      @(negedge clk);
      chk("hold_status", readdata, 32'h0000_0400);

      // Sequence from seed 01 at DIVISOR=0
      wr(2'd2, 32'h01);
      wr(2'd0, 32'h2);
      wr(2'd1, 32'h0);
      wr(2'd0, 32'h1);
      @(negedge clk);
      chk("seq_first_rise_clk", 32'(lfsr_clk), 32'h1);
      early = 0;
      for (int r = 1; r <= 255; r++) begin
         if (r <= 6) chk($sformatf("seq_rise%0d", r), 32'(lfsr_data), 32'(seq_exp[r-1]));
         if (r < 255 && lfsr_data == 8'h01) early++;
         if (r == 255) chk("seq_period_255", 32'(lfsr_data), 32'h01);
         if (r < 255) tick(2);
      end
      chk("seq_no_early_repeat", 32'(early), 32'h0);

      // Reset mid-run with DIVISOR=3
      wr(2'd1, 32'd3);
      tick(5);
      reset   = 1'b1;
      address = 2'd3;
      @(negedge clk);
      reset = 1'b0;
      chk("rst_clk", 32'(lfsr_clk), 32'h0);
      chk("rst_lfsr", 32'(lfsr_data), 32'h01);
      chk("rst_readdata", readdata, 32'h0);
      @(negedge clk);
      chk("rst_status", readdata, 32'h0000_0100);
      address = 2'd1;
      @(negedge clk);
      chk("rst_divisor", readdata, 32'h0);
      address = 2'd0;
      @(negedge clk);
      chk("rst_ctrl", readdata, 32'h0);

      // Load coincident with a 0->1 toggle
      wr(2'd2, 32'h5A);
      wr(2'd1, 32'd3);
      wr(2'd0, 32'h1);
      tick(3);
      wr(2'd0, 32'h3);
      chk("coll_clk", 32'(lfsr_clk), 32'h1);
      chk("coll_lfsr", 32'(lfsr_data), 32'h5A);
      tick(8);
      chk("coll_next_rise", 32'(lfsr_data), 32'hB4);

      // DIVISOR 9 -> 2 with counter at 7
      wr(2'd0, 32'h0);
      wr(2'd1, 32'd9);
      wr(2'd0, 32'h1);
      tick(7);
      wr(2'd1, 32'd2);
      chk("recfg_level_kept", 32'(lfsr_clk), 32'h1);
      tick(2);
      chk("recfg_no_early_toggle", 32'(lfsr_clk), 32'h1);
      tick(1);
      chk("recfg_toggle_at_3", 32'(lfsr_clk), 32'h0);
      chk("recfg_fall_no_step", 32'(lfsr_data), 32'hB4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
